fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller; drives the R7 program counter's PCen/wren/data controls.
//  Each instruction: addresses memory with the current PC, waits the memory latency,
//  latches the instruction word into IR and increments the PC. It then holds IR for the
//  execute unit and writes the PC on a taken branch.
//  Sits between the R7 counter, the instruction memory and the datapath control FSM.
// PARAMETERS
//  AW       6    PC / memory address width (matches R7 counter)
//  IW       9    instruction word width
//  MEM_LAT  1    cycles from mem_rden sample edge to mem_q valid; legal range 1..7
//  CNT_W    16   width of retired-instruction counter
// PORTS
//  Clock          in   1      clock, all state on posedge
//  reset          in   1      synchronous, active-high
//  Run            in   1      1 = keep fetching; 0 = stop at next instruction boundary
//  PC             in   AW     current R7 counter value
//  mem_q          in   IW     instruction memory read data
//  exec_done      in   1      execute unit finished current IR (sampled only in EXEC)
//  branch_req     in   1      with exec_done: load PC from branch_target
//  branch_target  in   AW     new PC value for taken branch
//  mem_addr       out  AW     memory address, = PC (combinational)
//  mem_rden       out  1      memory read strobe
//  PCen           out  1      R7 increment enable (one-cycle pulse)
//  pc_wren        out  1      R7 load enable (one-cycle pulse)
//  pc_data        out  AW     R7 load value
//  IR             out  IW     latched instruction register
//  ir_valid       out  1      IR holds an instruction awaiting execution
//  Done           out  1      one-cycle pulse when an instruction retires
//  instr_count    out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  Reset values: state=IDLE, IR=0, instr_count=0, wait cnt=0; all strobes 0; pc_data=0.
//  Reset has priority over every other input and aborts any state immediately.
//  States: IDLE, FETCH, WAIT, LOAD, EXEC.
//   IDLE : all strobes 0. Run=1 -> FETCH.
//   FETCH: mem_rden=1 (exactly one cycle); wait cnt <= MEM_LAT-1; -> WAIT.
//   WAIT : cnt==0 -> LOAD, else cnt <= cnt-1 (MEM_LAT=1 spends one WAIT cycle).
//   LOAD : IR <= mem_q; PCen=1 for this cycle only; -> EXEC.
//   EXEC : ir_valid=1. exec_done=0 -> stay.
//          exec_done=1: Done=1, instr_count += 1 (saturates at all-ones);
//          branch_req=1 also: pc_wren=1, pc_data=branch_target (same cycle);
//          next = Run ? FETCH : IDLE.
//  branch_req without exec_done is ignored. exec_done/branch_req are ignored outside EXEC.
//  PCen and pc_wren are never asserted in the same cycle.
//  The PC update lands on the edge leaving LOAD/EXEC, so FETCH always addresses the new PC.
//  Latency from FETCH to ir_valid: MEM_LAT+2 cycles. Instruction period: MEM_LAT+3 cycles + execute wait.
//  Run=0 mid-instruction: the current instruction completes; the block then stops in IDLE.
//  PC wrap: 2^AW-1 increments to 0 (done by the counter); the sequencer treats it as normal.
//  Branch to the PC of the current instruction is legal and refetches that instruction.
//  ir_valid falls the cycle after exec_done is accepted; IR holds until the next LOAD.
// TESTING
//  1 reset=1 for 2 cycles, Run=0 -> IDLE, all strobes 0, IR=0, instr_count=0.
//  2 Run=1, PC=0, mem_q=9'h1A5, MEM_LAT=1, exec_done one cycle after ir_valid ->
//    mem_rden cycle 0, PCen cycle 2, ir_valid cycle 3, IR=9'h1A5, Done cycle 4, count=1.
//  3 In EXEC with exec_done=1, branch_req=1, branch_target=6'd40 -> pc_wren=1, pc_data=40,
//    PCen=0; the next FETCH has mem_addr=40.
//  4 PC=6'd63, one instruction fetched -> PCen pulse, counter wraps to 0, next mem_addr=0.
//  5 Run dropped during WAIT -> instruction completes through EXEC, then IDLE, no further mem_rden.
//  6 reset asserted in EXEC with exec_done=1, branch_req=1 -> no Done, no pc_wren, IDLE next cycle.

Source files
------------

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
//  Bundle of every non-clock signal of the instruction-fetch sequencer:
//  - run control,
//  - R7 program-counter controls,
//  - instruction-memory read port,
//  - execute-unit handshake.
//
//  Modports
//   master : the fetch sequencer (drives strobes, IR and status)
//   slave  : the surrounding datapath / counter / memory / execute unit
//
//  Signals
//   Run            1      keep fetching; 0 = stop at next instruction boundary
//   PC             AW     current R7 counter value
//   mem_q          IW     instruction memory read data
//   exec_done      1      execute unit finished current IR
//   branch_req     1      with exec_done: load PC from branch_target
//   branch_target  AW     new PC value for a taken branch
//   mem_addr       AW     memory address (= PC)
//   mem_rden       1      memory read strobe
//   PCen           1      R7 increment enable
//   pc_wren        1      R7 load enable
//   pc_data        AW     R7 load value
//   IR             IW     latched instruction register
//   ir_valid       1      IR holds an instruction awaiting execution
//   Done           1      pulse when an instruction retires
//   instr_count    CNT_W  retired instructions, saturating
// ---------------------------------------------------------------------------
interface fetch_if #(
   parameter int AW    = 6,
   parameter int IW    = 9,
   parameter int CNT_W = 16
);
   logic             Run;
   logic [AW-1:0]    PC;
   logic [IW-1:0]    mem_q;
   logic             exec_done;
   logic             branch_req;
   logic [AW-1:0]    branch_target;
   logic [AW-1:0]    mem_addr;
   logic             mem_rden;
   logic             PCen;
   logic             pc_wren;
   logic [AW-1:0]    pc_data;
   logic [IW-1:0]    IR;
   logic             ir_valid;
   logic             Done;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  Run, PC, mem_q, exec_done, branch_req, branch_target,
      output mem_addr, mem_rden, PCen, pc_wren, pc_data, IR, ir_valid,
             Done, instr_count
   );

   modport slave (
      output Run, PC, mem_q, exec_done, branch_req, branch_target,
      input  mem_addr, mem_rden, PCen, pc_wren, pc_data, IR, ir_valid,
             Done, instr_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//  Instruction-fetch controller for the R7 program counter.
//
//  For each instruction it performs four steps:
//   1. addresses memory with the current PC,
//   2. waits out the memory latency,
//   3. latches the word into IR and pulses PCen,
//   4. holds IR for the execute unit until exec_done.
//  A taken branch (branch_req with exec_done) pulses pc_wren with
//  pc_data = branch_target in the retiring cycle.
//
//  Parameters
//   AW       PC / memory address width
//   IW       instruction word width
//   MEM_LAT  cycles from the mem_rden sample edge to valid mem_q (1..7)
//   CNT_W    retired-instruction counter width
//
//  Ports
//   Clock   in   clock, all state on posedge
//   reset   in   synchronous, active-high; also masks all strobes
//   bus     fetch_if.master (see fetch_if for the signal list)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int AW      = 6,
   parameter int IW      = 9,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic     Clock,
   input  logic     reset,
   fetch_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_EXEC
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [IW-1:0]    ir_q, ir_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic rden, pcen, wren, done;

   always_ff @(posedge Clock) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ir_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ir_q    <= ir_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch
      // of the case can leave a value unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ir_d    = ir_q;
      count_d = count_q;
      rden    = 1'b0;
      pcen    = 1'b0;
      wren    = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.Run) state_d = S_FETCH;
         end
         S_FETCH: begin
            rden    = 1'b1;
            cnt_d   = 3'(MEM_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Always spends at least one cycle here, so mem_q is sampled
            // MEM_LAT cycles after the edge that captured mem_rden.
            if (cnt_q == '0) state_d = S_LOAD;
            else             cnt_d   = cnt_q - 3'd1;
         end
         S_LOAD: begin
            ir_d    = bus.mem_q;
            pcen    = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // branch_req alone is ignored; it only matters when retiring.
            if (bus.exec_done) begin
               done    = 1'b1;
               wren    = bus.branch_req;
               count_d = (count_q == '1) ? count_q : count_q + 1'b1;
               state_d = bus.Run ? S_FETCH : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reset is synchronous, but it must abort the current cycle too: the
   // strobes are combinational, so they are masked while reset is high.
   assign bus.mem_addr    = bus.PC;
   assign bus.mem_rden    = rden & ~reset;
   assign bus.PCen        = pcen & ~reset;
   assign bus.pc_wren     = wren & ~reset;
   assign bus.Done        = done & ~reset;
   assign bus.pc_data     = (wren & ~reset) ? bus.branch_target : '0;
   assign bus.ir_valid    = (state_q == S_EXEC) & ~reset;
   assign bus.IR          = ir_q;
   assign bus.instr_count = count_q;

endmodule
